// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and RAM handshake state.
// Used by the memory arbiter and its RAM-side neighbours.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access.
// Ports: CLK/nRST; iREN/iaddr -> iload/ihit; dREN/dWEN/daddr/dstore ->
// dload/dhit/derr; ramREN/ramWEN/ramaddr/ramstore <- ramload/ramstate.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_RETRY  = 3,
    parameter int STARVE_LIM = 2
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      ihit,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dhit,
    output logic      derr,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT,
        RESP
    } state_t;

    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int SW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
    // The ERROR that arrives while retry_cnt holds this value is the last one tolerated.
    localparam logic [RW-1:0] RETRY_LAST = (MAX_RETRY < 1) ? '0 : RW'(MAX_RETRY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    state_t          state;
    word_t           addr_q;
    word_t           store_q;
    logic            wr_q;
    logic            data_q;
    logic            err_q;
    logic [RW-1:0]   retry_cnt;
    logic [SW-1:0]   starve_cnt;
    word_t           iload_q;
    word_t           dload_q;

    logic            dreq;
    logic            starved;

    assign dreq    = dREN | dWEN;
    assign starved = (starve_cnt == STARVE_MAX) && iREN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            wr_q       <= 1'b0;
            data_q     <= 1'b0;
            err_q      <= 1'b0;
            retry_cnt  <= '0;
            starve_cnt <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dreq && !starved) begin
                        state     <= DGRANT;
                        addr_q    <= daddr;
                        store_q   <= dstore;
                        wr_q      <= dWEN;
                        data_q    <= 1'b1;
                        err_q     <= 1'b0;
                        retry_cnt <= '0;
                        // Count data wins over a waiting fetch; saturates at the limit.
                        if (!iREN)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (iREN) begin
                        state      <= IGRANT;
                        addr_q     <= iaddr;
                        store_q    <= '0;
                        wr_q       <= 1'b0;
                        data_q     <= 1'b0;
                        err_q      <= 1'b0;
                        retry_cnt  <= '0;
                        starve_cnt <= '0;
                    end
                end
                DGRANT, IGRANT: begin
                    unique case (ramstate)
                        ACCESS: begin
                            state <= RESP;
                            if (data_q)
                                dload_q <= ramload;
                            else
                                iload_q <= ramload;
                        end
                        ERROR: begin
                            retry_cnt <= retry_cnt + 1'b1;
                            if (retry_cnt == RETRY_LAST) begin
                                state <= RESP;
                                err_q <= 1'b1;
                                if (!data_q)
                                    iload_q <= '1;
                            end
                        end
                        default: ;
                    endcase
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ramREN   = nRST && ((state == IGRANT) ||
                               ((state == DGRANT) && !wr_q));
    assign ramWEN   = nRST && (state == DGRANT) && wr_q;
    assign ihit     = nRST && (state == RESP) && !data_q;
    assign dhit     = nRST && (state == RESP) && data_q;
    assign derr     = dhit && err_q;
    assign iload    = iload_q;
    assign dload    = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Hand-computed expectations for load, contention, retry, reset, fetch.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      ihit;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dhit;
    logic      derr;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .derr     (derr),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
        step();
        step();
        chk("rst_ihit", 32'(ihit), 0);
        chk("rst_dhit", 32'(dhit), 0);
        chk("rst_derr", 32'(derr), 0);
        chk("rst_ren", 32'(ramREN), 0);
        chk("rst_wen", 32'(ramWEN), 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_store", ramstore, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        nRST = 1'b1;
        step();
        chk("idle_ren", 32'(ramREN), 0);

        // Load with two BUSY cycles; address change mid-grant is ignored.
        dREN     = 1'b1;
        daddr    = 32'h40;
        ramstate = BUSY;
        step();
        chk("ld_ren1", 32'(ramREN), 1);
        chk("ld_wen1", 32'(ramWEN), 0);
        chk("ld_addr1", ramaddr, 32'h40);
        daddr = 32'h80;
        step();
        chk("ld_ren2", 32'(ramREN), 1);
        chk("ld_stable", ramaddr, 32'h40);
        step();
        chk("ld_ren3", 32'(ramREN), 1);
        chk("ld_nohit", 32'(dhit), 0);
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
        step();
        chk("ld_dhit", 32'(dhit), 1);
        chk("ld_dload", dload, 32'hDEADBEEF);
        chk("ld_resp_ren", 32'(ramREN), 0);
        chk("ld_derr", 32'(derr), 0);
        dREN     = 1'b0;
        ramstate = FREE;
        step();
        chk("ld_hitdrop", 32'(dhit), 0);
        chk("ld_hold", dload, 32'hDEADBEEF);

        // Contention: two data wins, then the fetch is forced through.
        iREN     = 1'b1;
        iaddr    = 32'h100;
        dWEN     = 1'b1;
        daddr    = 32'h200;
        dstore   = 32'h11;
        ramstate = ACCESS;
        ramload  = 32'h0;
        step();
        chk("ct_wen1", 32'(ramWEN), 1);
        chk("ct_ren1", 32'(ramREN), 0);
        chk("ct_addr1", ramaddr, 32'h200);
        chk("ct_store1", ramstore, 32'h11);
        step();
        chk("ct_dhit1", 32'(dhit), 1);
        chk("ct_ihit1", 32'(ihit), 0);
        step();
        chk("ct_idle", 32'(dhit), 0);
        step();
        chk("ct_wen2", 32'(ramWEN), 1);
        step();
        chk("ct_dhit2", 32'(dhit), 1);
        step();
        step();
        chk("ct_ig_ren", 32'(ramREN), 1);
        chk("ct_ig_wen", 32'(ramWEN), 0);
        chk("ct_ig_addr", ramaddr, 32'h100);
        ramload = 32'hCAFE0001;
        step();
        chk("ct_ihit", 32'(ihit), 1);
        chk("ct_dhit3", 32'(dhit), 0);
        chk("ct_iload", iload, 32'hCAFE0001);
        iREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = FREE;
        step();

        // Store failing three times.
        dWEN     = 1'b1;
        daddr    = 32'h300;
        dstore   = 32'h55;
        ramstate = ERROR;
        step();
        chk("rt_wen1", 32'(ramWEN), 1);
        step();
        chk("rt_wen2", 32'(ramWEN), 1);
        step();
        chk("rt_wen3", 32'(ramWEN), 1);
        chk("rt_nohit", 32'(dhit), 0);
        dWEN = 1'b0;
        step();
        chk("rt_dhit", 32'(dhit), 1);
        chk("rt_derr", 32'(derr), 1);
        chk("rt_wen_resp", 32'(ramWEN), 0);
        ramstate = FREE;
        step();
        chk("rt_derr_drop", 32'(derr), 0);

        // Two errors then success.
        dREN     = 1'b1;
        daddr    = 32'h304;
        ramstate = ERROR;
        step();
        step();
        step();
        chk("rt2_ren", 32'(ramREN), 1);
        ramstate = ACCESS;
        ramload  = 32'h77;
        dREN     = 1'b0;
        step();
        chk("rt2_dhit", 32'(dhit), 1);
        chk("rt2_derr", 32'(derr), 0);
        chk("rt2_dload", dload, 32'h77);
        ramstate = FREE;
        step();

        // Fetch failing three times returns all ones.
        iREN     = 1'b1;
        iaddr    = 32'h380;
        ramstate = ERROR;
        step();
        step();
        step();
        iREN = 1'b0;
        step();
        chk("ie_ihit", 32'(ihit), 1);
        chk("ie_derr", 32'(derr), 0);
        chk("ie_iload", iload, 32'hFFFFFFFF);
        ramstate = FREE;
        step();

        // Reset during a fetch grant abandons it.
        iREN     = 1'b1;
        iaddr    = 32'h400;
        ramstate = BUSY;
        step();
        chk("rs_ren", 32'(ramREN), 1);
        chk("rs_addr", ramaddr, 32'h400);
        nRST = 1'b0;
        step();
        chk("rs_ren0", 32'(ramREN), 0);
        chk("rs_ihit0", 32'(ihit), 0);
        chk("rs_addr0", ramaddr, 0);
        chk("rs_iload0", iload, 0);
        nRST     = 1'b1;
        iREN     = 1'b0;
        ramstate = ACCESS;
        step();
        chk("rs_ihit1", 32'(ihit), 0);
        chk("rs_ren1", 32'(ramREN), 0);

        // Back-to-back fetches with immediate ACCESS.
        iREN  = 1'b1;
        iaddr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            ramload = 32'hA0 + 32'(k);
            step();
            chk("bb_addr", ramaddr, 32'h500 + 32'(4 * k));
            chk("bb_grant_hit", 32'(ihit), 0);
            step();
            chk("bb_ihit", 32'(ihit), 1);
            chk("bb_iload", iload, 32'hA0 + 32'(k));
            iaddr = iaddr + 32'd4;
            step();
            chk("bb_idle_hit", 32'(ihit), 0);
        end
        iREN     = 1'b0;
        ramstate = FREE;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: CLK input 1, rising-edge clock; nRST input 1, active-low reset sampled on the CLK rising edge.
REQ-002 The instruction-side ports SHALL be: iREN input 1 fetch request; iaddr input 32 fetch word address; iload output 32 fetched word; ihit output 1 one-cycle fetch-complete pulse.
REQ-003 The data-side ports SHALL be: dREN input 1 load request; dWEN input 1 store request; daddr input 32 data address; dstore input 32 store data; dload output 32 loaded word; dhit output 1 one-cycle data-complete pulse; derr output 1 pulse with dhit when the access failed.
REQ-004 The RAM-side ports SHALL be: ramREN output 1; ramWEN output 1; ramaddr output 32; ramstore output 32; ramload input 32; ramstate input ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-005 Parameter MAX_RETRY, default 3, SHALL set the number of ERROR responses tolerated per access.
REQ-006 Parameter STARVE_LIM, default 2, SHALL set the number of consecutive data grants allowed while iREN is pending.

Function
REQ-007 The FSM SHALL have the states IDLE, DGRANT, IGRANT and RESP.
REQ-008 In IDLE with a data request (dREN|dWEN), the block SHALL go to DGRANT unless starve_cnt==STARVE_LIM and iREN=1, in which case it SHALL go to IGRANT.
REQ-009 In IDLE with only iREN=1, the block SHALL go to IGRANT; with no request it SHALL stay in IDLE.
REQ-010 On leaving IDLE for a grant, the block SHALL latch the address, store data, op (dWEN overrides dREN when both are high) and the requester into internal registers.
REQ-011 ramaddr and ramstore SHALL be driven only from the latched registers, so requester input changes after the grant are ignored.
REQ-012 ramREN SHALL be 1 only in IGRANT, or in DGRANT on a load; ramWEN SHALL be 1 only in DGRANT on a store; both SHALL be 0 in IDLE and RESP.
REQ-013 In a grant state, ramstate==ACCESS SHALL capture ramload into the response register for the granted side and move the FSM to RESP.
REQ-014 In a grant state, ramstate FREE or BUSY SHALL hold the state with the RAM outputs stable.
REQ-015 In a grant state, ramstate==ERROR SHALL increment retry_cnt; when retry_cnt reaches MAX_RETRY, the FSM SHALL go to RESP with the error flag set, otherwise it SHALL stay in the grant state.
REQ-016 retry_cnt SHALL clear on every grant entry.
REQ-017 In RESP the block SHALL pulse ihit or dhit for exactly one cycle and then go to IDLE unconditionally.
REQ-018 derr SHALL pulse with dhit only on a failed data access; an instruction error SHALL pulse ihit with iload=32'hFFFFFFFF.
REQ-019 iload and dload SHALL hold their last captured value between responses.
REQ-020 Minimum latency SHALL be 3 cycles from request to hit (IDLE, grant with ACCESS, RESP).
REQ-021 After a hit, the requester drops its request, so the following IDLE cycle SHALL sample fresh requests.
REQ-022 starve_cnt SHALL increment on each DGRANT entry while iREN=1, clear on IGRANT entry, saturate at STARVE_LIM, and clear on a DGRANT entry with iREN=0.
REQ-023 On simultaneous iREN and a data request, data SHALL win unless the starvation limit is reached.

Reset
REQ-024 While nRST=0 at a clock edge, the block SHALL go to IDLE, clear retry_cnt, starve_cnt and the error flag, and zero iload, dload, ramaddr and ramstore.
REQ-025 While nRST=0, ihit, dhit, derr, ramREN and ramWEN SHALL be 0.
REQ-026 A reset mid-access SHALL abandon the access without a hit pulse.

Structure
REQ-027 ramstate_t and word_t SHALL come from cpu_types_pkg, and the FSM state enum SHALL be local to the module.
REQ-028 The block SHALL be a single module with no sub-modules.

Verification
REQ-029 Load: dREN=1, daddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles, dhit pulse with dload=0xDEADBEEF, 5 cycles total.
REQ-030 Contention: iREN=1 and dWEN=1 in the same cycle -> data store granted first; each data grant with iREN pending raises starve_cnt; a third data request is deferred so IGRANT occurs.
REQ-031 Retry: ramstate ERROR 3 times -> RESP with dhit=1 and derr=1, ramWEN held for all 3 cycles; 2 ERRORs then ACCESS -> dhit=1, derr=0.
REQ-032 Stability: daddr changed from 0x40 to 0x80 during DGRANT -> ramaddr stays 0x40.
REQ-033 Reset: nRST=0 during IGRANT -> next cycle IDLE, ramREN=0, no ihit.
REQ-034 Back-to-back fetches: iREN held with address increments and ACCESS immediate -> ihit every 3 cycles with correct iload.
